branch_int_sequencer: RTL and testbench
=======================================

// Module: branch_int_sequencer
// PURPOSE
//  Sequences PC redirection and pipeline flushes for the branch unit and
//  external interrupt entry. Resolves bu_op (JZ/JN/JC/JV/LOOP) against CCR
//  flags in EX, then drives pc_sel and the IF/ID and ID/EX flushes. Runs the
//  multi-cycle interrupt entry FSM and produces the registered sf1 flag that
//  the CU branch decoder uses to suppress bu_op.
// PARAMETERS
//  DRAIN_CYCLES  2   cycles sf1 stays high after vector fetch (range 1..7)
//  STAT_W        16  width of the statistics counters (used only with BIS_STATS_EN)
// PORTS
//  clk         in   1  single clock
//  rst         in   1  asynchronous, active-high reset
//  intr        in   1  external interrupt request, level; latched on rising edge
//  stall       in   1  pipeline stall (hazard unit); freezes FSM, no PC change
//  bu_op       in   3  branch op from CU, EX-stage copy
//  flag_z/n/c/v in  1  CCR flags as seen by the EX-stage instruction
//  loop_nz     in   1  LOOP decremented Ra != 0 (from ALU)
//  sf1         out  1  registered interrupt-in-progress flag, to the CU
//  pc_sel      out  2  00 PC+1, 01 branch target, 10 interrupt vector M[1]
//  flush_if_id out  1  squash the IF/ID register this cycle
//  flush_id_ex out  1  squash the ID/EX register this cycle
//  push_pc     out  1  one-cycle strobe: push the return PC and save the CCR
//  taken       out  1  branch resolved taken this cycle
//  busy        out  1  FSM not in IDLE
// BEHAVIOUR
//  - Reset (asynchronous): state=IDLE, int_pend=0, sf1=0, drain cnt=0. All
//    combinational outputs read 0 (pc_sel=00) while rst is high.
//  - Condition: taken = (001&z)|(010&n)|(011&c)|(100&v)|(101&loop_nz).
//    Codes 110/111 and 000 are never taken. taken is forced 0 when stall=1
//    or when state != IDLE.
//  - Branch, same cycle: pc_sel=01, flush_if_id=1, flush_id_ex=1. Zero added
//    latency; two bubbles.
//  - int_pend is set on intr 0->1 (edge register) and cleared on entering
//    INT_PUSH. A second edge while busy is held in int_pend, so one further
//    request is queued.
//  - FSM (every transition is blocked while stall=1):
//    IDLE     -> INT_PUSH when int_pend & !taken. If taken, the branch wins
//                and entry starts next cycle, so the target PC is saved.
//    INT_PUSH -> INT_VEC, 1 cycle: push_pc=1, sf1=1, flush_if_id=1.
//    INT_VEC  -> INT_DRAIN, 1 cycle: pc_sel=10, flush_if_id=1, flush_id_ex=1.
//    INT_DRAIN: counts DRAIN_CYCLES, then -> IDLE. sf1 goes 0 on the IDLE
//                entry edge.
//  - sf1 is a flop: set on the IDLE->INT_PUSH edge, cleared on the
//    INT_DRAIN->IDLE edge.
//  - Reset mid-sequence aborts immediately to IDLE. No partial push is
//    repeated.
// CONFIGURATION
//  - BIS_STATS_EN defined: adds outputs br_cnt[STAT_W] and int_cnt[STAT_W].
//    They count taken branches and INT_PUSH entries, saturate at all-ones
//    and reset to 0.
//  - Without it: the ports and counters are absent and behaviour is otherwise
//    identical.
// STRUCTURE
//  - Shared package cu_pkg holds:
//      BU_NONE/JZ/JN/JC/JV/LOOP = 3'b000..3'b101
//      PC_SEL_SEQ/BR/VEC = 2'b00/01/10
//      state encodings IDLE/INT_PUSH/INT_VEC/INT_DRAIN
//  - One combinational sub-module, branch_cond_eval (bu_op + flags -> taken).
//  - The FSM, edge detect and counters live in this module.
// TESTING
//  1. bu_op=001, z=1 -> taken=1, pc_sel=01, both flushes=1 the same cycle;
//     with z=0 -> pc_sel=00 and no flush.
//  2. bu_op=101: loop_nz=1 -> taken=1; loop_nz=0 -> taken=0.
//     bu_op=110 with all flags=1 -> taken=0.
//  3. intr rises in IDLE -> next cycle push_pc=1 and sf1=1; +1 cycle
//     pc_sel=10; sf1 stays 1 for 2 more cycles, then busy=0.
//  4. intr edge in the same cycle as a taken JC (c=1) -> branch is redirected
//     first; push_pc is asserted 1 cycle later than in scenario 3.
//  5. stall=1 for 3 cycles during INT_VEC -> state and outputs hold, no
//     pc_sel=10 until stall drops; a taken bu_op during stall is ignored.
//  6. rst asserted in INT_DRAIN -> sf1=0 and busy=0 asynchronously.
//     With BIS_STATS_EN: 3 taken branches -> br_cnt=3, and a saturation
//     check at 16'hFFFF.

Source files
------------

// File: rtl/cu_pkg.sv
// Shared control-unit definitions: branch op codes, PC select codes and the
// interrupt-entry state encoding.
package cu_pkg;

  localparam int unsigned BU_W     = 3;
  localparam int unsigned PC_SEL_W = 2;

  localparam logic [BU_W-1:0] BU_NONE = 3'b000;
  localparam logic [BU_W-1:0] BU_JZ   = 3'b001;
  localparam logic [BU_W-1:0] BU_JN   = 3'b010;
  localparam logic [BU_W-1:0] BU_JC   = 3'b011;
  localparam logic [BU_W-1:0] BU_JV   = 3'b100;
  localparam logic [BU_W-1:0] BU_LOOP = 3'b101;

  localparam logic [PC_SEL_W-1:0] PC_SEL_SEQ = 2'b00;
  localparam logic [PC_SEL_W-1:0] PC_SEL_BR  = 2'b01;
  localparam logic [PC_SEL_W-1:0] PC_SEL_VEC = 2'b10;

  typedef enum logic [1:0] {
    IDLE      = 2'b00,
    INT_PUSH  = 2'b01,
    INT_VEC   = 2'b10,
    INT_DRAIN = 2'b11
  } state_t;

  // Condition inputs seen by the EX-stage branch
  typedef struct packed {
    logic z;
    logic n;
    logic c;
    logic v;
    logic loop_nz;
  } cond_flags_t;

endpackage

// File: rtl/branch_int_sequencer_if.sv
// Pipeline-control bundle between the hazard/CU/ALU side and the branch and
// interrupt sequencer. br_cnt/int_cnt exist only when BIS_STATS_EN is defined.
interface branch_int_sequencer_if
`ifdef BIS_STATS_EN
  #(parameter int unsigned STAT_W = 16)
`endif
  ();
  import cu_pkg::*;

  logic                intr;
  logic                stall;
  logic [BU_W-1:0]     bu_op;
  logic                flag_z;
  logic                flag_n;
  logic                flag_c;
  logic                flag_v;
  logic                loop_nz;

  logic                sf1;
  logic [PC_SEL_W-1:0] pc_sel;
  logic                flush_if_id;
  logic                flush_id_ex;
  logic                push_pc;
  logic                taken;
  logic                busy;
`ifdef BIS_STATS_EN
  logic [STAT_W-1:0]   br_cnt;
  logic [STAT_W-1:0]   int_cnt;
`endif

  modport master (
    output intr, stall, bu_op, flag_z, flag_n, flag_c, flag_v, loop_nz,
    input  sf1, pc_sel, flush_if_id, flush_id_ex, push_pc, taken, busy
`ifdef BIS_STATS_EN
    , input br_cnt, int_cnt
`endif
  );

  modport slave (
    input  intr, stall, bu_op, flag_z, flag_n, flag_c, flag_v, loop_nz,
    output sf1, pc_sel, flush_if_id, flush_id_ex, push_pc, taken, busy
`ifdef BIS_STATS_EN
    , output br_cnt, int_cnt
`endif
  );

endinterface

// File: rtl/branch_cond_eval.sv
// Resolves the EX-stage branch op against the CCR flags / loop counter status.
module branch_cond_eval
  import cu_pkg::*;
(
  input  logic [BU_W-1:0] bu_op,
  input  cond_flags_t     flags,
  output logic            taken_c
);

  always_comb begin
    taken_c = 1'b0;
    case (bu_op)
      BU_NONE: taken_c = 1'b0;
      BU_JZ:   taken_c = flags.z;
      BU_JN:   taken_c = flags.n;
      BU_JC:   taken_c = flags.c;
      BU_JV:   taken_c = flags.v;
      BU_LOOP: taken_c = flags.loop_nz;
      default: taken_c = 1'b0;
    endcase
  end

endmodule

// File: rtl/branch_int_sequencer.sv
// PC redirection / flush sequencing for branches and interrupt entry.
// Optional statistics counters are built when BIS_STATS_EN is defined.
module branch_int_sequencer
  import cu_pkg::*;
#(
  parameter int unsigned DRAIN_CYCLES = 2
`ifdef BIS_STATS_EN
  , parameter int unsigned STAT_W = 16
`endif
) (
  input logic                   clk,
  input logic                   rst,
  branch_int_sequencer_if.slave bus
);

  localparam int unsigned      CNT_W      = 3;
  localparam logic [CNT_W-1:0] DRAIN_LAST = CNT_W'(DRAIN_CYCLES - 1);

  state_t              state, state_d;
  logic                intr_q;
  logic                int_pend, int_pend_d;
  logic                sf1, sf1_d;
  logic [CNT_W-1:0]    drain_cnt, drain_cnt_d;
  logic                rise, req, cond_taken, enter_push;
  logic                taken, push_pc, flush_if_id, flush_id_ex;
  logic [PC_SEL_W-1:0] pc_sel;
  cond_flags_t         flags;

  assign flags = '{z: bus.flag_z, n: bus.flag_n, c: bus.flag_c,
                   v: bus.flag_v, loop_nz: bus.loop_nz};

  branch_cond_eval u_cond (
    .bu_op   (bus.bu_op),
    .flags   (flags),
    .taken_c (cond_taken)
  );

  // Next state and control strobes; nothing advances while stalled or in reset
  always_comb begin
    state_d     = state;
    drain_cnt_d = drain_cnt;
    enter_push  = 1'b0;
    pc_sel      = PC_SEL_SEQ;
    flush_if_id = 1'b0;
    flush_id_ex = 1'b0;
    push_pc     = 1'b0;
    rise        = bus.intr & ~intr_q;
    req         = int_pend | rise;
    taken       = cond_taken & ~bus.stall & ~rst & (state == IDLE);

    if (!rst && !bus.stall) begin
      case (state)
        IDLE: begin
          // A taken branch wins; entry follows next cycle so the target is saved
          if (taken) begin
            pc_sel      = PC_SEL_BR;
            flush_if_id = 1'b1;
            flush_id_ex = 1'b1;
          end else if (req) begin
            state_d    = INT_PUSH;
            enter_push = 1'b1;
          end
        end
        INT_PUSH: begin
          push_pc     = 1'b1;
          flush_if_id = 1'b1;
          state_d     = INT_VEC;
        end
        INT_VEC: begin
          pc_sel      = PC_SEL_VEC;
          flush_if_id = 1'b1;
          flush_id_ex = 1'b1;
          drain_cnt_d = '0;
          state_d     = INT_DRAIN;
        end
        INT_DRAIN: begin
          if (drain_cnt == DRAIN_LAST) state_d = IDLE;
          else                         drain_cnt_d = drain_cnt + CNT_W'(1);
        end
        default: state_d = IDLE;
      endcase
    end

    // A fresh edge arriving while an older request is consumed stays queued
    int_pend_d = enter_push ? (int_pend & rise) : (int_pend | rise);

    sf1_d = sf1;
    if (enter_push)                                  sf1_d = 1'b1;
    else if (state == INT_DRAIN && state_d == IDLE)  sf1_d = 1'b0;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= IDLE;
      intr_q    <= 1'b0;
      int_pend  <= 1'b0;
      sf1       <= 1'b0;
      drain_cnt <= '0;
    end else begin
      state     <= state_d;
      intr_q    <= bus.intr;
      int_pend  <= int_pend_d;
      sf1       <= sf1_d;
      drain_cnt <= drain_cnt_d;
    end
  end

  assign bus.sf1         = sf1;
  assign bus.pc_sel      = pc_sel;
  assign bus.flush_if_id = flush_if_id;
  assign bus.flush_id_ex = flush_id_ex;
  assign bus.push_pc     = push_pc;
  assign bus.taken       = taken;
  assign bus.busy        = (state != IDLE) & ~rst;

`ifdef BIS_STATS_EN
  logic [STAT_W-1:0] br_cnt, int_cnt;

  // Saturating event counters
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      br_cnt  <= '0;
      int_cnt <= '0;
    end else begin
      if (taken && (br_cnt != '1))       br_cnt  <= br_cnt + STAT_W'(1);
      if (enter_push && (int_cnt != '1)) int_cnt <= int_cnt + STAT_W'(1);
    end
  end

  assign bus.br_cnt  = br_cnt;
  assign bus.int_cnt = int_cnt;
`endif

endmodule

// File: tb/tb_branch_int_sequencer.sv
// Directed bench for branch_int_sequencer: branch condition table plus
// interrupt-entry, stall and reset sequences (stats checks with BIS_STATS_EN).
module tb_branch_int_sequencer;
  import cu_pkg::*;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   n_vec = 0;
  int   n_err = 0;

  branch_int_sequencer_if bus ();

  branch_int_sequencer u_dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [2:0] op;
    logic       z, n, c, v, l;
    logic       exp_taken;
    logic [1:0] exp_sel;
    logic       exp_fl;
  } vec_t;

  vec_t vecs[12];

  task automatic chk1(input string name, input logic act, input logic exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %b expected %b", name, act, exp);
    end
  endtask

  task automatic chk2(input string name, input logic [1:0] act, input logic [1:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %b expected %b", name, act, exp);
    end
  endtask

  task automatic chk16(input string name, input logic [15:0] act, input logic [15:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic set_br(input logic [2:0] op, input logic z, input logic n,
                        input logic c, input logic v, input logic l);
    bus.bu_op   = op;
    bus.flag_z  = z;
    bus.flag_n  = n;
    bus.flag_c  = c;
    bus.flag_v  = v;
    bus.loop_nz = l;
  endtask

  task automatic wait_idle();
    int i = 0;
    while (bus.busy && i < 20) begin
      @(negedge clk);
      i++;
    end
    chk1("idle_timeout_busy", bus.busy, 1'b0);
  endtask

  initial begin
    //            op      z     n     c     v     l     tk    sel    fl
    vecs[0]  = '{3'b001, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 2'b01, 1'b1};
    vecs[1]  = '{3'b001, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 2'b00, 1'b0};
    vecs[2]  = '{3'b010, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 2'b01, 1'b1};
    vecs[3]  = '{3'b010, 1'b1, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 2'b00, 1'b0};
    vecs[4]  = '{3'b011, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 2'b01, 1'b1};
    vecs[5]  = '{3'b100, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 2'b01, 1'b1};
    vecs[6]  = '{3'b100, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 2'b00, 1'b0};
    vecs[7]  = '{3'b101, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 2'b01, 1'b1};
    vecs[8]  = '{3'b101, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 2'b00, 1'b0};
    vecs[9]  = '{3'b110, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 2'b00, 1'b0};
    vecs[10] = '{3'b111, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 2'b00, 1'b0};
    vecs[11] = '{3'b000, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 2'b00, 1'b0};

    bus.intr  = 1'b0;
    bus.stall = 1'b0;
    set_br(3'b001, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);

    // Outputs forced low while in reset, even with a taken branch presented
    #12;
    chk1("rst_taken", bus.taken, 1'b0);
    chk2("rst_pc_sel", bus.pc_sel, 2'b00);
    chk1("rst_flush_if_id", bus.flush_if_id, 1'b0);
    chk1("rst_flush_id_ex", bus.flush_id_ex, 1'b0);
    chk1("rst_sf1", bus.sf1, 1'b0);
    chk1("rst_busy", bus.busy, 1'b0);
    next_cycle();
    rst = 1'b0;
    set_br(3'b000, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);

    // Branch condition table
    for (int i = 0; i < 12; i++) begin
      next_cycle();
      set_br(vecs[i].op, vecs[i].z, vecs[i].n, vecs[i].c, vecs[i].v, vecs[i].l);
      @(negedge clk);
      chk1($sformatf("vec%0d_taken", i), bus.taken, vecs[i].exp_taken);
      chk2($sformatf("vec%0d_pc_sel", i), bus.pc_sel, vecs[i].exp_sel);
      chk1($sformatf("vec%0d_flush_if_id", i), bus.flush_if_id, vecs[i].exp_fl);
      chk1($sformatf("vec%0d_flush_id_ex", i), bus.flush_id_ex, vecs[i].exp_fl);
    end
    next_cycle();
    set_br(3'b000, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    @(negedge clk);

    // Interrupt entry from IDLE
    next_cycle();
    bus.intr = 1'b1;
    @(negedge clk);
    chk1("s3_pre_push", bus.push_pc, 1'b0);
    next_cycle();
    @(negedge clk);
    chk1("s3_push_pc", bus.push_pc, 1'b1);
    chk1("s3_push_sf1", bus.sf1, 1'b1);
    chk1("s3_push_flush_if_id", bus.flush_if_id, 1'b1);
    chk1("s3_push_flush_id_ex", bus.flush_id_ex, 1'b0);
    chk1("s3_push_busy", bus.busy, 1'b1);
    next_cycle();
    bus.intr = 1'b0;
    @(negedge clk);
    chk2("s3_vec_pc_sel", bus.pc_sel, 2'b10);
    chk1("s3_vec_flush_id_ex", bus.flush_id_ex, 1'b1);
    chk1("s3_vec_push_pc", bus.push_pc, 1'b0);
    chk1("s3_vec_sf1", bus.sf1, 1'b1);
    next_cycle();
    @(negedge clk);
    chk1("s3_drain1_sf1", bus.sf1, 1'b1);
    chk2("s3_drain1_pc_sel", bus.pc_sel, 2'b00);
    next_cycle();
    @(negedge clk);
    chk1("s3_drain2_sf1", bus.sf1, 1'b1);
    chk1("s3_drain2_busy", bus.busy, 1'b1);
    next_cycle();
    @(negedge clk);
    chk1("s3_done_sf1", bus.sf1, 1'b0);
    chk1("s3_done_busy", bus.busy, 1'b0);

    // Interrupt edge coincident with a taken JC: branch first, entry a cycle later
    next_cycle();
    bus.intr = 1'b1;
    set_br(BU_JC, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
    @(negedge clk);
    chk1("s4_taken", bus.taken, 1'b1);
    chk2("s4_pc_sel", bus.pc_sel, 2'b01);
    chk1("s4_push_early", bus.push_pc, 1'b0);
    next_cycle();
    set_br(3'b000, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    @(negedge clk);
    chk1("s4_push_late1", bus.push_pc, 1'b0);
    chk1("s4_busy_late1", bus.busy, 1'b0);
    next_cycle();
    @(negedge clk);
    chk1("s4_push_pc", bus.push_pc, 1'b1);
    chk1("s4_sf1", bus.sf1, 1'b1);
    next_cycle();
    bus.intr = 1'b0;
    wait_idle();

    // Stall held for three cycles in INT_VEC, with a taken branch presented
    next_cycle();
    bus.intr = 1'b1;
    @(negedge clk);
    next_cycle();
    @(negedge clk);
    chk1("s5_push_pc", bus.push_pc, 1'b1);
    next_cycle();
    bus.intr  = 1'b0;
    bus.stall = 1'b1;
    set_br(BU_JZ, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
    for (int k = 0; k < 3; k++) begin
      if (k > 0) next_cycle();
      @(negedge clk);
      chk2($sformatf("s5_stall%0d_pc_sel", k), bus.pc_sel, 2'b00);
      chk1($sformatf("s5_stall%0d_taken", k), bus.taken, 1'b0);
      chk1($sformatf("s5_stall%0d_flush_id_ex", k), bus.flush_id_ex, 1'b0);
      chk1($sformatf("s5_stall%0d_busy", k), bus.busy, 1'b1);
    end
    next_cycle();
    bus.stall = 1'b0;
    @(negedge clk);
    chk2("s5_vec_pc_sel", bus.pc_sel, 2'b10);
    chk1("s5_vec_taken", bus.taken, 1'b0);
    chk1("s5_vec_flush_id_ex", bus.flush_id_ex, 1'b1);
    next_cycle();
    set_br(3'b000, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    wait_idle();

    // Reset asserted in INT_DRAIN
    next_cycle();
    bus.intr = 1'b1;
    @(negedge clk);
    next_cycle();
    @(negedge clk);
    next_cycle();
    bus.intr = 1'b0;
    @(negedge clk);
    next_cycle();
    @(negedge clk);
    chk1("s6_drain_sf1", bus.sf1, 1'b1);
    chk1("s6_drain_busy", bus.busy, 1'b1);
    #2 rst = 1'b1;
    #1;
    chk1("s6_rst_sf1", bus.sf1, 1'b0);
    chk1("s6_rst_busy", bus.busy, 1'b0);
    chk2("s6_rst_pc_sel", bus.pc_sel, 2'b00);
    next_cycle();
    next_cycle();
    rst = 1'b0;
    @(negedge clk);
    chk1("s6_post_busy", bus.busy, 1'b0);
    chk1("s6_post_push", bus.push_pc, 1'b0);
    next_cycle();
    @(negedge clk);
    chk1("s6_post2_busy", bus.busy, 1'b0);
    chk1("s6_post2_push", bus.push_pc, 1'b0);

`ifdef BIS_STATS_EN
    chk16("st_br_rst", bus.br_cnt, 16'h0000);
    chk16("st_int_rst", bus.int_cnt, 16'h0000);
    next_cycle();
    set_br(BU_JZ, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
    repeat (3) @(posedge clk);
    #1;
    set_br(3'b000, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    @(negedge clk);
    chk16("st_br_three", bus.br_cnt, 16'h0003);
    next_cycle();
    bus.intr = 1'b1;
    next_cycle();
    @(negedge clk);
    chk16("st_int_one", bus.int_cnt, 16'h0001);
    next_cycle();
    bus.intr = 1'b0;
    wait_idle();
    next_cycle();
    set_br(BU_JZ, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
    repeat (65540) @(posedge clk);
    #1;
    set_br(3'b000, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    @(negedge clk);
    chk16("st_br_sat", bus.br_cnt, 16'hFFFF);
`endif

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
